// File: rtl/jtframe_kabuki_pkg.sv
// Shared constants, state type and checksum helper for the Kabuki key loader.
// Optional checksum byte enabled with `define JTFRAME_KABUKI_CHK_EN.
package jtframe_kabuki_pkg;

    localparam int unsigned KABUKI_KEY_BYTES = 11;
    localparam int unsigned KABUKI_KEY_W     = KABUKI_KEY_BYTES * 8;
    localparam int unsigned KABUKI_AW        = 26;
    localparam int unsigned KABUKI_CNT_W     = 4;

`ifdef JTFRAME_KABUKI_CHK_EN
    localparam int unsigned KABUKI_WIN = KABUKI_KEY_BYTES + 1;
`else
    localparam int unsigned KABUKI_WIN = KABUKI_KEY_BYTES;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_PLAY,
        ST_DONE
    } kabuki_st_e;

`ifdef JTFRAME_KABUKI_CHK_EN
    function automatic logic [7:0] kabuki_xor(input logic [KABUKI_KEY_W-1:0] key);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < int'(KABUKI_KEY_BYTES); i++) x ^= key[i*8 +: 8];
        return x;
    endfunction
`endif

endpackage

// File: rtl/jtframe_kabuki_keyld_if.sv
// Download-side and decoder-side signals of the Kabuki key loader.
interface jtframe_kabuki_keyld_if;
    import jtframe_kabuki_pkg::*;

    logic                 downloading;
    logic [KABUKI_AW-1:0] ioctl_addr;
    logic [7:0]           ioctl_dout;
    logic                 ioctl_wr;
    logic [7:0]           prog_data;
    logic                 prog_we;
    logic                 kabuki_en;
    logic                 key_ok;
    logic                 busy;

    modport master (
        output downloading, ioctl_addr, ioctl_dout, ioctl_wr,
        input  prog_data, prog_we, kabuki_en, key_ok, busy
    );

    modport slave (
        input  downloading, ioctl_addr, ioctl_dout, ioctl_wr,
        output prog_data, prog_we, kabuki_en, key_ok, busy
    );
endinterface

// File: rtl/jtframe_kabuki_pace.sv
// Replay pacing counter: after start, ticks every GAP cycles until aborted.
module jtframe_kabuki_pace #(
    parameter int unsigned GAP = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic abort_i,
    output logic tick_c
);
    localparam int unsigned CW = 4;

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // First tick lands GAP-1 cycles after start, so the registered strobe is GAP cycles in.
    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        tick_c = 1'b0;
        if (abort_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start_i) begin
            run_d = 1'b1;
            cnt_d = '0;
        end else if (run_q) begin
            if (cnt_q == CW'(GAP - 1)) begin
                tick_c = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/jtframe_kabuki_keyld.sv
// Captures the Kabuki key bytes from the ROM download and replays them to the decoder.
// `define JTFRAME_KABUKI_CHK_EN adds a trailing XOR checksum byte to the window.
module jtframe_kabuki_keyld
    import jtframe_kabuki_pkg::*;
#(
    parameter logic [KABUKI_AW-1:0] KEY_ADDR = 26'h0,
    parameter int unsigned          GAP      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jtframe_kabuki_keyld_if.slave  bus
);
    localparam int unsigned IDX_W = 4;

    kabuki_st_e              st_q, st_d;
    logic                    dl_q;
    logic [KABUKI_WIN-1:0]   valid_q, valid_d, cap_valid;
    logic [KABUKI_CNT_W-1:0] cnt_q, cnt_d, cap_cnt;
    logic [KABUKI_KEY_W-1:0] key_q, cap_key;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              prog_data_q, prog_data_d;
    logic                    prog_we_q, prog_we_d;
    logic                    kab_q, kab_d, ok_q, ok_d, busy_q, busy_d;
    logic [KABUKI_AW-1:0]    off_c;
    logic [3:0]              off4_c;
    logic                    rise_c, fall_c, in_win_c, full_c, start_c, abort_c, tick_c;
`ifdef JTFRAME_KABUKI_CHK_EN
    logic [7:0]              chk_q, cap_chk;
`endif

    assign rise_c   =  bus.downloading & ~dl_q;
    assign fall_c   = ~bus.downloading &  dl_q;
    // Modular offset turns both window bounds into one unsigned compare.
    assign off_c    = bus.ioctl_addr - KEY_ADDR;
    assign off4_c   = off_c[3:0];
    assign in_win_c = off_c < KABUKI_AW'(KABUKI_WIN);

    // Key buffer and valid bits as updated by this cycle's download write.
    always_comb begin
        cap_key   = key_q;
        cap_valid = valid_q;
        cap_cnt   = cnt_q;
`ifdef JTFRAME_KABUKI_CHK_EN
        cap_chk   = chk_q;
`endif
        if (st_q == ST_CAPTURE && bus.ioctl_wr && in_win_c) begin
            if (!valid_q[off4_c]) cap_cnt = cnt_q + KABUKI_CNT_W'(1);
            cap_valid[off4_c] = 1'b1;
`ifdef JTFRAME_KABUKI_CHK_EN
            if (off4_c == 4'(KABUKI_KEY_BYTES)) cap_chk = bus.ioctl_dout;
            else
`endif
            cap_key[{off4_c, 3'b000} +: 8] = bus.ioctl_dout;
        end
    end

`ifdef JTFRAME_KABUKI_CHK_EN
    assign full_c = (cap_cnt == KABUKI_CNT_W'(KABUKI_WIN)) && (kabuki_xor(cap_key) == cap_chk);
`else
    assign full_c = (cap_cnt == KABUKI_CNT_W'(KABUKI_WIN));
`endif

    assign start_c = (st_q == ST_CAPTURE) && fall_c && full_c;
    assign abort_c = (st_q == ST_PLAY) && (rise_c || idx_q == IDX_W'(KABUKI_KEY_BYTES));

    jtframe_kabuki_pace #(.GAP(GAP)) u_pace (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_c),
        .abort_i (abort_c),
        .tick_c  (tick_c)
    );

    always_comb begin
        st_d        = st_q;
        valid_d     = cap_valid;
        cnt_d       = cap_cnt;
        idx_d       = idx_q;
        prog_we_d   = 1'b0;
        prog_data_d = prog_data_q;
        kab_d       = kab_q;
        ok_d        = ok_q;
        unique case (st_q)
            ST_IDLE: ;
            ST_CAPTURE: begin
                if (fall_c) begin
                    st_d  = start_c ? ST_PLAY : ST_DONE;
                    idx_d = '0;
                    kab_d = 1'b0;
                    ok_d  = 1'b0;
                end
            end
            ST_PLAY: begin
                if (idx_q == IDX_W'(KABUKI_KEY_BYTES)) begin
                    st_d  = ST_DONE;
                    kab_d = 1'b1;
                    ok_d  = 1'b1;
                end else if (tick_c) begin
                    prog_we_d   = 1'b1;
                    prog_data_d = key_q[{idx_q, 3'b000} +: 8];
                    idx_d       = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: ;
            default: st_d = ST_IDLE;
        endcase
        // A new download always restarts capture, cancelling any replay.
        if (rise_c && st_q != ST_CAPTURE) begin
            st_d      = ST_CAPTURE;
            valid_d   = '0;
            cnt_d     = '0;
            kab_d     = 1'b0;
            ok_d      = 1'b0;
            prog_we_d = 1'b0;
        end
        busy_d = (st_d == ST_CAPTURE) || (st_d == ST_PLAY);
    end

    // dl_q resets high so a download already active at release is not seen as a new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            dl_q        <= 1'b1;
            valid_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            prog_we_q   <= 1'b0;
            prog_data_q <= '0;
            kab_q       <= 1'b0;
            ok_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            dl_q        <= bus.downloading;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            prog_we_q   <= prog_we_d;
            prog_data_q <= prog_data_d;
            kab_q       <= kab_d;
            ok_q        <= ok_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        key_q <= cap_key;
`ifdef JTFRAME_KABUKI_CHK_EN
        chk_q <= cap_chk;
`endif
    end

    assign bus.prog_data = prog_data_q;
    assign bus.prog_we   = prog_we_q;
    assign bus.kabuki_en = kab_q;
    assign bus.key_ok    = ok_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_jtframe_kabuki_keyld.sv
// Directed bench for the Kabuki key loader with a replay scoreboard.
module tb_jtframe_kabuki_keyld;
    import jtframe_kabuki_pkg::*;

    localparam int unsigned GAP      = 2;
    localparam logic [25:0] KEY_ADDR = 26'h000_100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    jtframe_kabuki_keyld_if bus();

    jtframe_kabuki_keyld #(.KEY_ADDR(KEY_ADDR), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         cyc        = 0;
    int         n_pulse    = 0;
    int         end_cyc    = 0;
    int         last_cyc   = 0;
    int         first_lat  = 0;
    bit         new_replay = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] key[KABUKI_KEY_BYTES];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every strobe must match the next expected key byte.
    always @(negedge clk) begin
        if (rst_n && bus.prog_we === 1'b1) begin
            n_pulse++;
            if (new_replay) begin
                first_lat  = cyc - end_cyc;
                new_replay = 1'b0;
            end else begin
                check("pulse_gap", 32'(cyc - last_cyc), 32'(GAP));
            end
            last_cyc = cyc;
            check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("prog_data", 32'(bus.prog_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [25:0] a, input logic [7:0] d);
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        @(negedge clk);
        bus.ioctl_wr   = 1'b0;
        @(negedge clk);
    endtask

    task automatic dl_begin();
        bus.downloading = 1'b1;
        tick(2);
    endtask

    task automatic send_key(input logic [7:0] base, input int skip);
        for (int i = 0; i < int'(KABUKI_KEY_BYTES); i++) begin
            key[i] = base + 8'(i);
            if (i != skip) wr(KEY_ADDR + 26'(i), key[i]);
        end
    endtask

`ifdef JTFRAME_KABUKI_CHK_EN
    task automatic send_chk(input logic [7:0] flip);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < int'(KABUKI_KEY_BYTES); i++) x ^= key[i];
        wr(KEY_ADDR + 26'(KABUKI_KEY_BYTES), x ^ flip);
    endtask
`endif

    task automatic dl_end(input bit expect_play);
        if (expect_play)
            for (int i = 0; i < int'(KABUKI_KEY_BYTES); i++) exp_q.push_back(key[i]);
        bus.downloading = 1'b0;
        end_cyc    = cyc;
        new_replay = 1'b1;
        tick(1);
        check("busy_after_end", 32'(bus.busy), 32'(expect_play));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 200), 32'd1);
        tick(3);
    endtask

    task automatic check_full_replay(input string tag, input int p0);
        wait_idle(tag);
        check({tag, "_pulses"}, 32'(n_pulse - p0), 32'(KABUKI_KEY_BYTES));
        check({tag, "_first_lat"}, 32'(first_lat), 32'(GAP + 1));
        check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_kabuki_en"}, 32'(bus.kabuki_en), 32'd1);
        check({tag, "_key_ok"}, 32'(bus.key_ok), 32'd1);
    endtask

    task automatic wait_pulses(input int n, input string tag);
        int seen, budget;
        seen   = 0;
        budget = 0;
        while (seen < n && budget < 200) begin
            @(negedge clk);
            if (bus.prog_we === 1'b1) seen++;
            budget++;
        end
        check({tag, "_wait"}, 32'(seen), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bus.downloading = 1'b0;
        bus.ioctl_addr  = '0;
        bus.ioctl_dout  = '0;
        bus.ioctl_wr    = 1'b0;
        tick(3);
        check("rst_prog_we", 32'(bus.prog_we), 32'd0);
        check("rst_prog_data", 32'(bus.prog_data), 32'd0);
        check("rst_kabuki_en", 32'(bus.kabuki_en), 32'd0);
        check("rst_key_ok", 32'(bus.key_ok), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Full key with stray writes just outside both window edges.
        p0 = n_pulse;
        dl_begin();
        check("capture_busy", 32'(bus.busy), 32'd1);
        wr(KEY_ADDR - 26'd1, 8'hEE);
        wr(KEY_ADDR + 26'(KABUKI_WIN), 8'hEE);
        send_key(8'h10, -1);
`ifdef JTFRAME_KABUKI_CHK_EN
        send_chk(8'h00);
`endif
        dl_end(1'b1);
        check_full_replay("basic", p0);

        // Missing byte 5: no replay, decoder left disabled.
        p0 = n_pulse;
        dl_begin();
        check("miss_clear_en", 32'(bus.kabuki_en), 32'd0);
        send_key(8'h60, 5);
`ifdef JTFRAME_KABUKI_CHK_EN
        send_chk(8'h00);
`endif
        dl_end(1'b0);
        tick(40);
        check("miss_pulses", 32'(n_pulse - p0), 32'd0);
        check("miss_kabuki_en", 32'(bus.kabuki_en), 32'd0);
        check("miss_key_ok", 32'(bus.key_ok), 32'd0);

        // Rewrite of byte 3: last value wins, count unaffected.
        p0 = n_pulse;
        dl_begin();
        send_key(8'h40, -1);
        wr(KEY_ADDR + 26'd3, 8'hAA);
        wr(KEY_ADDR + 26'd3, 8'h55);
        key[3] = 8'h55;
`ifdef JTFRAME_KABUKI_CHK_EN
        send_chk(8'h00);
`endif
        dl_end(1'b1);
        check_full_replay("rewrite", p0);

        // Abort after the 4th strobe, then a clean second download.
        p0 = n_pulse;
        dl_begin();
        send_key(8'h30, -1);
`ifdef JTFRAME_KABUKI_CHK_EN
        send_chk(8'h00);
`endif
        dl_end(1'b1);
        wait_pulses(4, "abort");
        bus.downloading = 1'b1;
        tick(1);
        check("abort_kabuki_en", 32'(bus.kabuki_en), 32'd0);
        check("abort_key_ok", 32'(bus.key_ok), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd1);
        exp_q.delete();
        tick(20);
        check("abort_pulses", 32'(n_pulse - p0), 32'd4);
        p0 = n_pulse;
        send_key(8'hA0, -1);
`ifdef JTFRAME_KABUKI_CHK_EN
        send_chk(8'h00);
`endif
        dl_end(1'b1);
        check_full_replay("reload", p0);

        // Reset during replay, with downloading held high across release.
        dl_begin();
        send_key(8'hC0, -1);
`ifdef JTFRAME_KABUKI_CHK_EN
        send_chk(8'h00);
`endif
        dl_end(1'b1);
        wait_pulses(2, "rst_play");
        rst_n = 1'b0;
        #1;
        check("rstp_prog_we", 32'(bus.prog_we), 32'd0);
        check("rstp_prog_data", 32'(bus.prog_data), 32'd0);
        check("rstp_kabuki_en", 32'(bus.kabuki_en), 32'd0);
        check("rstp_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        bus.downloading = 1'b1;
        tick(2);
        rst_n = 1'b1;
        p0 = n_pulse;
        tick(3);
        check("held_no_capture", 32'(bus.busy), 32'd0);
        send_key(8'h70, -1);
        bus.downloading = 1'b0;
        tick(5);
        check("held_busy", 32'(bus.busy), 32'd0);
        check("held_pulses", 32'(n_pulse - p0), 32'd0);
        check("held_kabuki_en", 32'(bus.kabuki_en), 32'd0);
        dl_begin();
        send_key(8'h80, -1);
`ifdef JTFRAME_KABUKI_CHK_EN
        send_chk(8'h00);
`endif
        dl_end(1'b1);
        check_full_replay("after_rst", p0);

`ifdef JTFRAME_KABUKI_CHK_EN
        // Checksum off by one bit: capture rejected.
        p0 = n_pulse;
        dl_begin();
        send_key(8'h90, -1);
        send_chk(8'h01);
        dl_end(1'b0);
        tick(40);
        check("badchk_pulses", 32'(n_pulse - p0), 32'd0);
        check("badchk_kabuki_en", 32'(bus.kabuki_en), 32'd0);
        check("badchk_key_ok", 32'(bus.key_ok), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jtframe_kabuki_keyld.md
JTFRAME_KABUKI_KEYLD -- requirements
Module: jtframe_kabuki_keyld

Interface
REQ-001 SHALL have parameter KEY_ADDR, default 26'h0, download byte address of the first key byte.
REQ-002 SHALL have parameter GAP, default 2, cycles between successive prog_we pulses; legal range 1..15.
REQ-003 clk  input  1  system clock, same as the SDRAM/decoder clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 downloading  input  1  ROM download in progress.
REQ-006 ioctl_addr  input  26  download byte address.
REQ-007 ioctl_dout  input  8  download data byte.
REQ-008 ioctl_wr  input  1  download byte strobe, one cycle per byte.
REQ-009 prog_data  output  8  key byte to the decoder key shifter.
REQ-010 prog_we  output  1  one-cycle shift strobe to the decoder.
REQ-011 kabuki_en  output  1  decoder enable.
REQ-012 key_ok  output  1  all key bytes captured and replayed.
REQ-013 busy  output  1  capture or replay in progress.

Function
REQ-014 SHALL hold an 11-entry x 8-bit key buffer plus a 4-bit capture count (0..11).
REQ-015 States SHALL be IDLE, CAPTURE, PLAY, DONE; busy=1 in CAPTURE and PLAY only.
REQ-016 IDLE->CAPTURE on the rising edge of downloading, clearing the capture count, kabuki_en and key_ok in the same cycle.
REQ-017 In CAPTURE, ioctl_wr with ioctl_addr in KEY_ADDR..KEY_ADDR+10 SHALL write ioctl_dout to entry ioctl_addr-KEY_ADDR and set that entry's valid bit; the count is the number of valid bits, and a rewrite of the same address SHALL overwrite the entry without double counting.
REQ-018 Writes outside the window, or when ioctl_wr=0, SHALL be ignored.
REQ-019 CAPTURE->PLAY on the falling edge of downloading when all 11 valid bits are set; otherwise CAPTURE->DONE with key_ok=0 and kabuki_en=0.
REQ-020 In PLAY, SHALL issue exactly 11 prog_we pulses, entry 0 first and entry 10 last, one every GAP cycles, the first pulse GAP cycles after entering PLAY; prog_data SHALL be stable in the pulse cycle.
REQ-021 The cycle after the 11th pulse SHALL enter DONE with key_ok=1 and kabuki_en=1.
REQ-022 A rising edge of downloading in PLAY or DONE SHALL abort to CAPTURE with kabuki_en=0 and key_ok=0 the next cycle, and SHALL issue no further prog_we.
REQ-023 prog_we SHALL never assert outside PLAY.
REQ-024 The edge detection of downloading SHALL use a one-cycle registered copy; the output response latency is one cycle.

Reset
REQ-025 On rst_n=0: state IDLE, prog_we=0, prog_data=0, kabuki_en=0, key_ok=0, busy=0, all valid bits cleared, pacing counter 0.
REQ-026 If downloading=1 at reset release, a rising edge SHALL NOT be inferred; the block SHALL wait for the next rising edge.

Configuration
REQ-027 With JTFRAME_KABUKI_CHK_EN defined, the window SHALL be 12 bytes; the 12th byte SHALL be a checksum equal to the XOR of bytes 0..10 and SHALL NOT be replayed.
REQ-028 With JTFRAME_KABUKI_CHK_EN defined and a checksum mismatch, the block SHALL go CAPTURE->DONE with key_ok=0 and kabuki_en=0, and SHALL issue no prog_we.
REQ-029 Without the macro, the window SHALL be 11 bytes and there SHALL be no checksum logic.

Structure
REQ-030 A shared package jtframe_kabuki_pkg SHALL hold KABUKI_KEY_BYTES=11, the state enum type and the 88-bit key width constant.
REQ-031 One sub-module, jtframe_kabuki_pace, SHALL implement the GAP pacing counter with start, abort and tick.
REQ-032 The decoder SHALL be instantiated by the parent, not inside this block.

Verification
REQ-033 Download of bytes 0x10..0x1A at KEY_ADDR..+10 with GAP=2 -> 11 prog_we pulses, 2 cycles apart, data 0x10..0x1A in order, then kabuki_en=1 and key_ok=1.
REQ-034 Download omitting address KEY_ADDR+5 -> no prog_we, DONE with kabuki_en=0 and key_ok=0.
REQ-035 New download started after the 4th prog_we pulse -> no 5th pulse, kabuki_en=0, re-capture, then a full 11-pulse replay after the second download.
REQ-036 Address KEY_ADDR+3 written twice, 0xAA then 0x55 -> the replayed 4th byte is 0x55 and the pulse count stays 11.
REQ-037 rst_n low during PLAY -> all outputs 0 immediately; with downloading held high through release, no capture occurs until the next rising edge.
REQ-038 With JTFRAME_KABUKI_CHK_EN defined, a 12th byte equal to the XOR of the key bytes -> 11 pulses and kabuki_en=1; a 12th byte of that XOR^0x01 -> no pulses, kabuki_en=0.
